spi_frame_receiver: RTL

- Parametrised SPI slave receiver: the MCU streams a frame of pixel words into the edge-detection core over sdi/ncs.
- Deserialises WORD_BITS-wide words in either bit order and extracts the DATA_BITS-wide pixel field.
- Generates a write strobe plus a frame-relative write address for the image buffer, and flags end-of-frame and aborted words.
- Sits between the SPI pins and the frame buffer write port, entirely in the spiClk domain.

---
 rtl/spi_rx_pkg.sv | 11 +
 rtl/spi_rx_shifter.sv | 41 ++++
 rtl/spi_frame_receiver.sv | 87 ++++++++
 3 files changed

// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared state type, default parameters and bit-placement helper for the SPI frame receiver
package spi_rx_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} spiRxState_t;
  localparam int WORD_BITS_DEF = 16;
  localparam int DATA_BITS_DEF = 12;
  localparam int MSB_FIRST_DEF = 1;
  localparam int FRAME_WORDS_DEF = 256;
  function automatic int bit_index(input int k, input int msb_first, input int word_bits);
    return msb_first != 0 ? word_bits - 1 - k : k;
  endfunction
endpackage

// File: rtl/spi_rx_shifter.sv
// spi_rx_shifter: bit counter and bit-order-aware deserialiser, updated on the falling edge of spiClk
//   spiClk, nreset        clock (falling edge active) and async active-low reset
//   cap_i, clr_i, sdi_i   capture sdi this edge, drop the partial word, serial data
//   word_complete_o       this edge captures the last bit of a word
//   pixel_o               top DATA_BITS of the word including the bit captured this edge
module spi_rx_shifter
  import spi_rx_pkg::*;
#(
  parameter int WORD_BITS = WORD_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic                 spiClk,
  input  logic                 nreset,
  input  logic                 cap_i,
  input  logic                 clr_i,
  input  logic                 sdi_i,
  output logic                 word_complete_o,
  output logic [DATA_BITS-1:0] pixel_o
);
  localparam int CW = $clog2(WORD_BITS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  assign word_complete_o = cap_i && cnt_q == CW'(WORD_BITS - 1);
  // the count returns to 0 on completion so a back-to-back word starts at bit 0 with no gap clock
  assign cnt_d = (clr_i || word_complete_o) ? '0 : cap_i ? cnt_q + CW'(1) : cnt_q;
  always_comb begin
    word_d = word_q;
    for (int i = 0; i < WORD_BITS; i++)
      if (cap_i && i == bit_index(int'(cnt_q), MSB_FIRST, WORD_BITS)) word_d[i] = sdi_i;
  end
  assign pixel_o = word_d[WORD_BITS-1 -: DATA_BITS];
  always_ff @(negedge spiClk or negedge nreset)
    if (!nreset) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
endmodule

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver: SPI slave that deserialises pixel words and emits frame-buffer write strobes
//   spiClk, nreset   clock (all state on falling edge), async active-low reset
//   sdi, ncs         serial data and active-low chip select
//   writeData/Addr   committed pixel field and frame-relative address, valid with writeEnable
//   writeEnable      one-period commit strobe; frameDone accompanies the last word of a frame
//   wordAbort        one-period strobe when ncs rises with a partial word
//   frameChecksum    XOR of all pixels of the last completed frame (only with SPI_RX_CHECKSUM_EN)
module spi_frame_receiver
  import spi_rx_pkg::*;
#(
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int MSB_FIRST   = MSB_FIRST_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int ADDR_BITS   = $clog2(FRAME_WORDS)
) (
  input  logic                 spiClk,
  input  logic                 nreset,
  input  logic                 sdi,
  input  logic                 ncs,
  output logic [DATA_BITS-1:0] writeData,
  output logic [ADDR_BITS-1:0] writeAddr,
  output logic                 writeEnable,
  output logic                 frameDone,
  output logic                 wordAbort
`ifdef SPI_RX_CHECKSUM_EN
  ,
  output logic [DATA_BITS-1:0] frameChecksum
`endif
);
  spiRxState_t state_q;
  logic [ADDR_BITS-1:0] idx_q, addr_q;
  logic [DATA_BITS-1:0] data_q, pixel;
  logic we_q, done_q, abort_q, word_done, last;
  spi_rx_shifter #(
    .WORD_BITS(WORD_BITS),
    .DATA_BITS(DATA_BITS),
    .MSB_FIRST(MSB_FIRST)
  ) u_shifter (
    .spiClk         (spiClk),
    .nreset         (nreset),
    .cap_i          (!ncs),
    .clr_i          (ncs),
    .sdi_i          (sdi),
    .word_complete_o(word_done),
    .pixel_o        (pixel)
  );
  assign last = idx_q == ADDR_BITS'(FRAME_WORDS - 1);
  always_ff @(negedge spiClk or negedge nreset)
    if (!nreset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      // completion can only happen in SHIFT; any state with ncs low captures a bit and shifts
      state_q <= word_done ? COMMIT : ncs ? IDLE : SHIFT;
      we_q    <= word_done;
      done_q  <= word_done && last;
      abort_q <= state_q == SHIFT && ncs;
      if (word_done) begin
        data_q <= pixel;
        addr_q <= idx_q;
        idx_q  <= last ? '0 : idx_q + ADDR_BITS'(1);
      end
    end
  assign writeData   = data_q;
  assign writeAddr   = addr_q;
  assign writeEnable = we_q;
  assign frameDone   = done_q;
  assign wordAbort   = abort_q;
`ifdef SPI_RX_CHECKSUM_EN
  logic [DATA_BITS-1:0] acc_q, chk_q;
  always_ff @(negedge spiClk or negedge nreset)
    if (!nreset) begin
      acc_q <= '0;
      chk_q <= '0;
    end else if (word_done) begin
      acc_q <= last ? '0 : acc_q ^ pixel;
      if (last) chk_q <= acc_q ^ pixel;
    end
  assign frameChecksum = chk_q;
`endif
endmodule
